// File: rtl/sram_ctrl_pkg.sv
// Shared widths and FSM state encoding for the async SRAM controller.
package sram_ctrl_pkg;

    localparam int SRAM_AW = 20;
    localparam int SRAM_DW = 48;
    localparam int BUS_DW  = 32;
    localparam int BE_W    = BUS_DW / 8;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD       = 3'd1,
        RMW_RD   = 3'd2,
        WR_SETUP = 3'd3,
        WR_PULSE = 3'd4,
        WR_HOLD  = 3'd5,
        DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side word port of the SRAM controller: request fields in, read data and status out.
interface sram_ctrl_if;
    import sram_ctrl_pkg::*;

    logic               req;
    logic               we;
    logic [SRAM_AW-1:0] addr;
    logic [BUS_DW-1:0]  wdata;
    logic [BE_W-1:0]    be;
    logic [BUS_DW-1:0]  rdata;
    logic               ack;
    logic               busy;

    modport master (
        output req, we, addr, wdata, be,
        input  rdata, ack, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output rdata, ack, busy
    );

endinterface

// File: rtl/sram_byte_merge.sv
// Combinational byte merge for read-modify-write: enabled bytes of wdata replace the
// low 32 bits of the old word, bits 47:32 always come from the old word.
module sram_byte_merge
    import sram_ctrl_pkg::*;
(
    input  logic [SRAM_DW-1:0] old_word,
    input  logic [BUS_DW-1:0]  wdata,
    input  logic [BE_W-1:0]    be,
    output logic [SRAM_DW-1:0] merged
);

    always_comb begin
        merged = old_word;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/sram_ctrl.sv
// Word-port to async 48-bit SRAM bridge; read ack after RD_WAIT, full write after WR_WAIT+1,
// partial write after RD_WAIT+WR_WAIT+1 cycles. One request at a time; req ignored while busy.
module sram_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 2
) (
    input  logic               clk,
    input  logic               rst,
    sram_ctrl_if.slave         bus,
    output logic [SRAM_AW-1:0] SRAM_ADDR,
    output logic               SRAM_CE,
    output logic               SRAM_OEN,
    output logic               SRAM_WEN,
    inout  wire  [SRAM_DW-1:0] SRAM_DQ
);

    localparam logic [3:0] RD_LOAD = 4'(RD_WAIT - 1);
    localparam logic [3:0] WR_LOAD = 4'(WR_WAIT - 1);
    localparam logic [BE_W-1:0] BE_ALL = '1;

    state_t             state, next_state;
    logic [3:0]         cnt, next_cnt;
    logic [BUS_DW-1:0]  wdata_q;
    logic [BE_W-1:0]    be_q;
    logic [SRAM_DW-1:0] wr_word;
    logic [SRAM_DW-1:0] merged;
    logic               dq_oe;
    logic               accept;
    logic               ce_d, oen_d, wen_d, oe_d, ack_d, busy_d;

    assign accept = (state == IDLE) && bus.req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= next_state;
            cnt   <= next_cnt;
        end
    end

    always_comb begin
        next_state = state;
        next_cnt   = cnt;
        case (state)
            IDLE: begin
                if (bus.req) begin
                    if (!bus.we) begin
                        next_state = RD;
                        next_cnt   = RD_LOAD;
                    end else if (bus.be == '0) begin
                        next_state = DONE;
                    end else if (bus.be == BE_ALL) begin
                        next_state = WR_SETUP;
                    end else begin
                        next_state = RMW_RD;
                        next_cnt   = RD_LOAD;
                    end
                end
            end
            RD: begin
                if (cnt == '0) next_state = DONE;
                else           next_cnt   = cnt - 4'd1;
            end
            RMW_RD: begin
                if (cnt == '0) next_state = WR_SETUP;
                else           next_cnt   = cnt - 4'd1;
            end
            WR_SETUP: begin
                next_state = WR_PULSE;
                next_cnt   = WR_LOAD;
            end
            WR_PULSE: begin
                if (cnt == '0) next_state = WR_HOLD;
                else           next_cnt   = cnt - 4'd1;
            end
            WR_HOLD: next_state = IDLE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Decoded from next_state so every pin comes straight from a flop.
    always_comb begin
        ce_d   = 1'b1;
        oen_d  = 1'b1;
        wen_d  = 1'b1;
        oe_d   = 1'b0;
        ack_d  = 1'b0;
        busy_d = (next_state != IDLE);
        case (next_state)
            RD, RMW_RD: begin
                ce_d  = 1'b0;
                oen_d = 1'b0;
            end
            WR_SETUP: begin
                ce_d = 1'b0;
                oe_d = 1'b1;
            end
            WR_PULSE: begin
                ce_d  = 1'b0;
                wen_d = 1'b0;
                oe_d  = 1'b1;
            end
            WR_HOLD: begin
                ce_d  = 1'b0;
                oe_d  = 1'b1;
                ack_d = 1'b1;
            end
            DONE:    ack_d = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SRAM_CE  <= 1'b1;
            SRAM_OEN <= 1'b1;
            SRAM_WEN <= 1'b1;
            dq_oe    <= 1'b0;
            bus.ack  <= 1'b0;
            bus.busy <= 1'b0;
        end else begin
            SRAM_CE  <= ce_d;
            SRAM_OEN <= oen_d;
            SRAM_WEN <= wen_d;
            dq_oe    <= oe_d;
            bus.ack  <= ack_d;
            bus.busy <= busy_d;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            SRAM_ADDR <= '0;
            bus.rdata <= '0;
            wdata_q   <= '0;
            be_q      <= '0;
            wr_word   <= '0;
        end else begin
            if (accept) begin
                SRAM_ADDR <= bus.addr;
                wdata_q   <= bus.wdata;
                be_q      <= bus.be;
                wr_word   <= {{(SRAM_DW-BUS_DW){1'b0}}, bus.wdata};
            end
            if (state == RD && cnt == '0) begin
                bus.rdata <= SRAM_DQ[BUS_DW-1:0];
            end
            // Old word is sampled on the same edge that releases OEN and starts the write.
            if (state == RMW_RD && cnt == '0) begin
                wr_word <= merged;
            end
        end
    end

    sram_byte_merge u_merge (
        .old_word (SRAM_DQ),
        .wdata    (wdata_q),
        .be       (be_q),
        .merged   (merged)
    );

    assign SRAM_DQ = dq_oe ? wr_word : {SRAM_DW{1'bz}};

endmodule

// File: tb/tb_sram_ctrl.sv
// Randomised scoreboard bench for sram_ctrl with a behavioural SRAM and reference memory.
module tb_sram_ctrl;
    import sram_ctrl_pkg::*;

    localparam int RD_WAIT = 2;
    localparam int WR_WAIT = 2;
    localparam logic [47:0] RELEASED = 48'hFFFF_FFFF_FFFF;

    typedef struct {
        logic [19:0] a;
        logic [31:0] rd;
        int          lat;
        int          oen_cyc;
        int          wen_cyc;
        int          wen_first;
        int          ce_cyc;
        logic [47:0] mem_after;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    sram_ctrl_if bus_if ();
    logic [19:0] sram_addr;
    logic        sram_ce, sram_oen, sram_wen;
    wire  [47:0] dq;

    sram_ctrl #(.RD_WAIT(RD_WAIT), .WR_WAIT(WR_WAIT)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus_if),
        .SRAM_ADDR (sram_addr),
        .SRAM_CE   (sram_ce),
        .SRAM_OEN  (sram_oen),
        .SRAM_WEN  (sram_wen),
        .SRAM_DQ   (dq)
    );

    // External SRAM: drives DQ while selected and output-enabled, stores while WEN is low.
    logic [47:0] sram_mem [0:(1<<20)-1];
    logic        pl_en = 1'b0;
    logic [19:0] pl_a  = '0;
    logic [47:0] pl_v  = '0;

    pullup pu_dq [47:0] (dq);
    assign dq = (!sram_ce && !sram_oen) ? sram_mem[sram_addr] : {48{1'bz}};

    always @(posedge clk) begin
        if (pl_en)                     sram_mem[pl_a]      <= pl_v;
        else if (!sram_ce && !sram_wen) sram_mem[sram_addr] <= dq;
    end

    logic [47:0] ref_mem [bit [19:0]];
    exp_t        q[$];
    int          nchk = 0, npass = 0;
    int          n_issued = 0, ack_cnt = 0;
    logic [31:0] last_rd = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [47:0] ref_rd(input logic [19:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 48'h0;
    endfunction

    task automatic preload(input logic [19:0] a, input logic [47:0] v);
        pl_a = a; pl_v = v; pl_en = 1'b1;
        @(posedge clk); #1;
        pl_en = 1'b0;
        ref_mem[a] = v;
    endtask

    task automatic issue(input logic w, input logic [19:0] a, input logic [31:0] d,
                         input logic [3:0] b, input bit keep);
        exp_t        e;
        logic [47:0] old_w, new_w;
        bit          partial, got;
        old_w   = ref_rd(a);
        new_w   = old_w;
        partial = w && (b != 4'h0) && (b != 4'hF);
        e.a = a;
        if (!w) begin
            e.lat = RD_WAIT; e.oen_cyc = RD_WAIT; e.wen_cyc = 0; e.wen_first = -1; e.ce_cyc = RD_WAIT;
            last_rd = old_w[31:0];
        end else if (b == 4'h0) begin
            e.lat = 0; e.oen_cyc = 0; e.wen_cyc = 0; e.wen_first = -1; e.ce_cyc = 0;
        end else begin
            e.lat       = partial ? RD_WAIT + WR_WAIT + 1 : WR_WAIT + 1;
            e.oen_cyc   = partial ? RD_WAIT : 0;
            e.wen_cyc   = WR_WAIT;
            e.wen_first = partial ? RD_WAIT + 1 : 1;
            e.ce_cyc    = -1;
            if (!partial) new_w = {16'h0000, d};
            else for (int i = 0; i < 4; i++) if (b[i]) new_w[8*i +: 8] = d[8*i +: 8];
            ref_mem[a] = new_w;
        end
        e.rd        = last_rd;
        e.mem_after = new_w;
        q.push_back(e);
        n_issued++;
        bus_if.req = 1'b1; bus_if.we = w; bus_if.addr = a; bus_if.wdata = d; bus_if.be = b;
        got = 1'b0;
        for (int i = 0; i < 64 && !got; i++) begin
            @(posedge clk); #1;
            got = bus_if.ack;
        end
        if (!got) begin
            nchk++;
            $display("FAIL ack_timeout: no ack for addr %h within 64 cycles", a);
        end
        @(posedge clk); #1;
        if (!keep) bus_if.req = 1'b0;
    endtask

    // Monitor: measures each transaction from busy rising and checks it at ack.
    int   cyc, oc, wc, wf, cc, viol;
    bit   in_txn = 0, prev_busy = 0, post_chk = 0;
    exp_t post_e, me;

    always @(negedge clk) begin
        if (rst) begin
            in_txn = 0; prev_busy = 0; post_chk = 0;
        end else begin
            if (post_chk) begin
                post_chk = 0;
                chk("idle_gap_busy", 64'(bus_if.busy), 64'd0);
                chk("ack_one_cycle", 64'(bus_if.ack), 64'd0);
                chk("dq_released", 64'(dq), 64'(RELEASED));
                chk("mem_contents", 64'(sram_mem[post_e.a]), 64'(post_e.mem_after));
            end
            if (bus_if.busy && !prev_busy) begin
                in_txn = 1; cyc = 0; oc = 0; wc = 0; wf = -1; cc = 0; viol = 0;
            end else if (in_txn) begin
                cyc++;
            end
            if (in_txn) begin
                if (!sram_oen) oc++;
                if (!sram_ce) cc++;
                if (!sram_wen) begin
                    wc++;
                    if (wf < 0) wf = cyc;
                end
                if (!sram_wen && !sram_oen) viol++;
                if (!sram_oen && dq !== sram_mem[sram_addr]) viol++;
            end
            if (bus_if.ack) begin
                ack_cnt++;
                if (q.size() == 0) begin
                    nchk++;
                    $display("FAIL unexpected_ack: ack with empty scoreboard at %0t", $time);
                end else begin
                    me = q.pop_front();
                    chk("ack_latency", 64'(cyc), 64'(me.lat));
                    chk("rdata", 64'(bus_if.rdata), 64'(me.rd));
                    chk("oen_low_cycles", 64'(oc), 64'(me.oen_cyc));
                    chk("wen_low_cycles", 64'(wc), 64'(me.wen_cyc));
                    chk("wen_first_cycle", 64'(wf), 64'(me.wen_first));
                    if (me.ce_cyc >= 0) chk("ce_low_cycles", 64'(cc), 64'(me.ce_cyc));
                    chk("bus_protocol", 64'(viol), 64'd0);
                    post_e   = me;
                    post_chk = 1;
                end
                in_txn = 0;
            end
            prev_busy = bus_if.busy;
        end
    end

    initial begin
        logic [19:0] pool [8];
        bus_if.req = 1'b0; bus_if.we = 1'b0; bus_if.addr = '0; bus_if.wdata = '0; bus_if.be = '0;
        rst = 1'b1;
        preload(20'h00010, 48'h0000_DEADBEEF);
        preload(20'h00005, 48'hABCD_11223344);
        preload(20'h00030, 48'h0123_89ABCDEF);
        preload(20'h00040, 48'h7777_00000040);
        preload(20'h80000, 48'h5555_CAFEF00D);
        preload(20'hFFFFF, 48'h1234_0BADC0DE);
        for (int i = 0; i < 8; i++) begin
            pool[i] = 20'h00100 + 20'(i * 3);
            preload(pool[i], {1'b0, 15'($urandom), 32'($urandom)});
        end

        chk("rst_ce", 64'(sram_ce), 64'd1);
        chk("rst_oen", 64'(sram_oen), 64'd1);
        chk("rst_wen", 64'(sram_wen), 64'd1);
        chk("rst_addr", 64'(sram_addr), 64'd0);
        chk("rst_rdata", 64'(bus_if.rdata), 64'd0);
        chk("rst_ack", 64'(bus_if.ack), 64'd0);
        chk("rst_busy", 64'(bus_if.busy), 64'd0);
        chk("rst_dq", 64'(dq), 64'(RELEASED));
        rst = 1'b0;
        @(posedge clk); #1;

        issue(1'b0, 20'h00010, 32'h0, 4'hF, 1'b0);
        issue(1'b1, 20'h00020, 32'h12345678, 4'hF, 1'b0);
        issue(1'b1, 20'h00005, 32'h0000AA00, 4'b0010, 1'b0);
        issue(1'b0, 20'h00005, 32'h0, 4'h0, 1'b0);
        issue(1'b1, 20'h00030, 32'hFFFFFFFF, 4'h0, 1'b0);

        // Reset during the first WEN-low cycle of a full write.
        bus_if.req = 1'b1; bus_if.we = 1'b1; bus_if.addr = 20'h00040;
        bus_if.wdata = 32'hA5A5A5A5; bus_if.be = 4'hF;
        @(posedge clk);
        @(posedge clk); #2;
        rst = 1'b1; #1;
        chk("abort_wen", 64'(sram_wen), 64'd1);
        chk("abort_ce", 64'(sram_ce), 64'd1);
        chk("abort_oen", 64'(sram_oen), 64'd1);
        chk("abort_dq", 64'(dq), 64'(RELEASED));
        chk("abort_busy", 64'(bus_if.busy), 64'd0);
        chk("abort_ack", 64'(bus_if.ack), 64'd0);
        bus_if.req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_rd = '0;
        @(posedge clk); #1;
        issue(1'b0, 20'h00040, 32'h0, 4'hF, 1'b0);

        issue(1'b1, 20'h7FFFF, 32'h600DF00D, 4'hF, 1'b1);
        issue(1'b0, 20'h80000, 32'h0, 4'hF, 1'b1);
        issue(1'b0, 20'hFFFFF, 32'h0, 4'hF, 1'b0);
        issue(1'b0, 20'h7FFFF, 32'h0, 4'hF, 1'b0);

        for (int n = 0; n < 40; n++) begin
            bit keep;
            keep = ($urandom_range(0, 3) == 0);
            issue(1'($urandom_range(0, 1)), pool[$urandom_range(0, 7)], $urandom,
                  4'($urandom_range(0, 15)), keep);
            if (!keep) begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
            end
        end
        bus_if.req = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        chk("ack_count", 64'(ack_cnt), 64'(n_issued));
        chk("scoreboard_empty", 64'(q.size()), 64'd0);
        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
